// File: rtl/fifo_pkg.sv
// Constants shared by the synchronous FIFO, its stream reader and their benches.
// Also holds the occupancy encoding of the reader's 2-entry output buffer.
package fifo_pkg;

  localparam int FIFO_WIDTH = 8;
  localparam int FIFO_DEPTH = 16;
  localparam int XFER_CNT_W = 16;

  localparam logic [1:0] OCC_0 = 2'd0;
  localparam logic [1:0] OCC_1 = 2'd1;
  localparam logic [1:0] OCC_2 = 2'd2;

  // Entries that will be held once the in-flight read lands and a pending pop retires.
  function automatic logic [2:0] occ_after(input logic [1:0] occ,
                                           input logic       inflight,
                                           input logic       pop);
    return {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
  endfunction

endpackage

// File: rtl/fifo_stream_skid.sv
// Two-entry in-order buffer: head is always the oldest word and drives the output register.
// Push and pop may happen together; push into a full buffer is ignored unless it pops too.
module fifo_stream_skid
  import fifo_pkg::*;
#(
  parameter int width = FIFO_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [width-1:0] push_data_i,
  input  logic             pop_i,
  output logic [width-1:0] head_data_o,
  output logic             head_valid_o,
  output logic [1:0]       occ_o
);

  logic [width-1:0] head_q, head_d;
  logic [width-1:0] tail_q, tail_d;
  logic [1:0]       occ_q, occ_d;
  logic             pop_ok, push_ok;

  assign pop_ok  = pop_i & (occ_q != OCC_0);
  assign push_ok = push_i & ((occ_q != OCC_2) | pop_ok);

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    unique case ({push_ok, pop_ok})
      2'b10: begin
        if (occ_q == OCC_0) begin
          head_d = push_data_i;
          occ_d  = OCC_1;
        end else begin
          tail_d = push_data_i;
          occ_d  = OCC_2;
        end
      end
      2'b01: begin
        if (occ_q == OCC_2) begin
          head_d = tail_q;
          occ_d  = OCC_1;
        end else begin
          occ_d  = OCC_0;
        end
      end
      2'b11: begin
        // Occupancy is unchanged: the head advances and the new word takes the tail.
        if (occ_q == OCC_2) begin
          head_d = tail_q;
          tail_d = push_data_i;
        end else begin
          head_d = push_data_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= OCC_0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  assign head_data_o  = head_q;
  assign head_valid_o = (occ_q != OCC_0);
  assign occ_o        = occ_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Consumer side of the synchronous FIFO: issues r_en, absorbs the one-cycle read latency
// and re-presents the words as a valid/ready stream through a 2-entry buffer.
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int width = FIFO_WIDTH,
  parameter int cnt_w = XFER_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             fifo_empty,
  input  logic [width-1:0] fifo_data,
  output logic             fifo_r_en,
  output logic [width-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [cnt_w-1:0] xfer_cnt,
  output logic             busy
);

  // Stream handshake: a word moves when m_valid & m_ready at posedge; m_valid never
  // waits on m_ready, and m_data/m_valid hold steady until that word is taken.
  logic             pop;
  logic             room;
  logic             inflight_q, inflight_d;
  logic [1:0]       occ;
  logic             head_valid;
  logic [width-1:0] head_data;
  logic [cnt_w-1:0] xfer_cnt_q, xfer_cnt_d;

  assign pop  = head_valid & m_ready;
  // A read may only go out if the word it returns is guaranteed a free slot.
  assign room = (occ_after(occ, inflight_q, pop) <= 3'd1);

  always_comb begin
    fifo_r_en  = rst & en & ~fifo_empty & room;
    inflight_d = fifo_r_en;
    xfer_cnt_d = xfer_cnt_q + {{(cnt_w-1){1'b0}}, pop};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight_q <= 1'b0;
      xfer_cnt_q <= '0;
    end else begin
      inflight_q <= inflight_d;
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

  fifo_stream_skid #(
    .width (width)
  ) u_skid (
    .clk_i        (clk),
    .rst_ni       (rst),
    .push_i       (inflight_q),
    .push_data_i  (fifo_data),
    .pop_i        (pop),
    .head_data_o  (head_data),
    .head_valid_o (head_valid),
    .occ_o        (occ)
  );

  assign m_data   = head_data;
  assign m_valid  = head_valid;
  assign xfer_cnt = xfer_cnt_q;
  assign busy     = head_valid | inflight_q;

endmodule
